// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter_if                                      |
// | Description : Bundle of the two writeback request channels and the       |
// |               register-file write port driven by regfile_wb_arbiter.     |
// |   master : writeback sources and register-file side (drives requests,    |
// |            observes ready and the write port)                            |
// |   slave  : the arbiter (takes requests, drives ready and write port)     |
// |   req0_*       ALU writeback request (valid/addr/data, ready back)       |
// |   req1_*       mult/div writeback request (valid/addr/data, ready back)  |
// |   wr_en        registered write strobe                                   |
// |   wr_addr      registered write address                                  |
// |   wr_data      registered write data                                     |
// |   wr_onehot    registered decoded per-register enable vector             |
// |   conflict_cnt saturating count of cycles with both requesters valid     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  localparam int NREG = 2 ** ADDR_W;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   wr_onehot;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data, wr_onehot, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data, wr_onehot, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                         |
// | Description : Two-way round-robin arbiter for the register file's single |
// |               write port (requester 0 = ALU, 1 = mult/div). Registers    |
// |               the winning address/data, drives a one-hot enable vector,  |
// |               suppresses writes to register 0 and counts conflicts.      |
// |   clk  : system clock, rising-edge active                                |
// |   clr  : asynchronous active-high reset                                  |
// |   bus  : slave side of regfile_wb_arbiter_if (requests in, ready and     |
// |          registered write port out)                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  wire                 clk,
  input  wire                 clr,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic              prio;        // 0: requester 0 favoured on a conflict
  logic              grant0;
  logic              grant1;
  logic              transfer;
  logic              conflict;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   sel_onehot;
  logic              sel_is_r0;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NREG-1:0]   wr_onehot_q;
  logic [CNT_W-1:0]  cnt_q;

  // A lone requester always wins; prio only breaks ties. The two grant
  // terms are mutually exclusive by construction.
  always_comb begin
    conflict   = bus.req0_valid & bus.req1_valid;
    grant0     = bus.req0_valid & (~bus.req1_valid | ~prio);
    grant1     = bus.req1_valid & (~bus.req0_valid |  prio);
    transfer   = grant0 | grant1;
    sel_addr   = grant1 ? bus.req1_addr : bus.req0_addr;
    sel_data   = grant1 ? bus.req1_data : bus.req0_data;
    sel_is_r0  = (sel_addr == '0);
    sel_onehot = {{(NREG-1){1'b0}}, 1'b1} << sel_addr;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prio        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_onehot_q <= '0;
      cnt_q       <= '0;
    end else begin
      // Strobe and enables are single-cycle pulses; address/data hold.
      wr_en_q     <= 1'b0;
      wr_onehot_q <= '0;
      if (transfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        // Register 0 is hardwired: accept the request but fire no enable.
        if (!sel_is_r0) begin
          wr_en_q     <= 1'b1;
          wr_onehot_q <= sel_onehot;
        end
        // Favour whoever lost (or did not ask) this time.
        prio <= grant0;
      end
      if (conflict && !(&cnt_q)) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_onehot    = wr_onehot_q;
  assign bus.conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                      |
// | Description : Self-checking bench for regfile_wb_arbiter: behavioural    |
// |               model compared every cycle plus directed literal checks.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic chk = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_prio = 0;
  int          m_cnt  = 0;
  logic        e_en     = 1'b0;
  logic [31:0] e_addr   = '0;
  logic [31:0] e_data   = '0;
  logic [63:0] e_onehot = '0;

  // Returns the index of the winner, or -1 if nobody asks.
  function automatic int winner(input logic v0, input logic v1, input int p);
    if (v0 && v1) return p;
    if (v0)       return 0;
    if (v1)       return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge clr) begin
    int w;
    int a;
    if (clr) begin
      m_prio = 0; m_cnt = 0;
      e_en = 1'b0; e_addr = '0; e_data = '0; e_onehot = '0;
    end else begin
      w = winner(bus.req0_valid, bus.req1_valid, m_prio);
      if (bus.req0_valid && bus.req1_valid && m_cnt < CMAX) m_cnt = m_cnt + 1;
      e_en = 1'b0; e_onehot = '0;
      if (w >= 0) begin
        a      = (w == 0) ? int'(bus.req0_addr) : int'(bus.req1_addr);
        e_addr = a;
        e_data = (w == 0) ? bus.req0_data : bus.req1_data;
        if (a != 0) begin
          e_en     = 1'b1;
          e_onehot = longint'(1) << a;
        end
        m_prio = 1 - w;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    int w;
    if (chk) begin
      w = winner(bus.req0_valid, bus.req1_valid, m_prio);
      check("model_ready0", bus.req0_ready, (w == 0));
      check("model_ready1", bus.req1_ready, (w == 1));
      check("model_wr_en", bus.wr_en, e_en);
      check("model_wr_addr", bus.wr_addr, e_addr);
      check("model_wr_data", bus.wr_data, e_data);
      check("model_wr_onehot", bus.wr_onehot, e_onehot);
      check("model_conflict_cnt", bus.conflict_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v0, input int a0, input logic [31:0] d0,
                       input logic v1, input int a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0[ADDR_W-1:0]; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1[ADDR_W-1:0]; bus.req1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 clr = 1'b1;
    chk = 1'b1;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'($urandom), int'($urandom_range(0, 31)), $urandom,
            1'($urandom), int'($urandom_range(0, 31)), $urandom);
      #1;
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_wr_onehot", bus.wr_onehot, 64'h0);
      check("rst_wr_data", bus.wr_data, 64'h0);
      check("rst_conflict_cnt", bus.conflict_cnt, 64'h0);
    end
    idle();
    clr = 1'b0;
    drive(1'b1, 4, 32'h44, 1'b1, 6, 32'h66);
    #1;
    check("rst_ready0", bus.req0_ready, 1'b1);
    check("rst_ready1", bus.req1_ready, 1'b0);
    idle();  // withdraw before the edge
    tick();

    // Single requester 0 -> r7.
    drive(1'b1, 7, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    #1 check("single_ready0", bus.req0_ready, 1'b1);
    tick();
    idle();
    check("single_wr_en", bus.wr_en, 1'b1);
    check("single_wr_addr", bus.wr_addr, 64'd7);
    check("single_wr_onehot", bus.wr_onehot, 64'h80);
    check("single_wr_data", bus.wr_data, 64'hDEADBEEF);
    tick();
    check("single_wr_en_drop", bus.wr_en, 1'b0);
    check("single_wr_addr_hold", bus.wr_addr, 64'd7);

    // Requester 1 -> r0 is granted but suppressed; prio returns to 0.
    drive(1'b0, 0, 32'h0, 1'b1, 0, 32'h1234);
    #1 check("r0_ready1", bus.req1_ready, 1'b1);
    tick();
    idle();
    check("r0_wr_en", bus.wr_en, 1'b0);
    check("r0_wr_onehot", bus.wr_onehot, 64'h0);
    check("r0_wr_addr", bus.wr_addr, 64'd0);
    check("r0_wr_data", bus.wr_data, 64'h1234);

    // Conflict alternation: grants 0,1,0,1.
    drive(1'b1, 3, 32'h30, 1'b1, 9, 32'h90);
    #1 check("alt_ready0_c0", bus.req0_ready, 1'b1);
    tick();
    check("alt_addr_c0", bus.wr_addr, 64'd3);
    check("alt_onehot_c0", bus.wr_onehot, 64'h8);
    check("alt_ready1_c1", bus.req1_ready, 1'b1);
    tick();
    check("alt_addr_c1", bus.wr_addr, 64'd9);
    check("alt_onehot_c1", bus.wr_onehot, 64'h200);
    check("alt_data_c1", bus.wr_data, 64'h90);
    check("alt_ready0_c2", bus.req0_ready, 1'b1);
    tick();
    check("alt_addr_c2", bus.wr_addr, 64'd3);
    check("alt_ready1_c3", bus.req1_ready, 1'b1);
    tick();
    check("alt_addr_c3", bus.wr_addr, 64'd9);
    check("alt_wr_en_c3", bus.wr_en, 1'b1);
    check("alt_conflict_cnt", bus.conflict_cnt, 64'd4);
    idle();
    tick();

    // Saturation: 20 more conflict cycles from a count of 4.
    drive(1'b1, 12, 32'hC0C0, 1'b1, 21, 32'h2121);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9)  check("sat_cnt_14", bus.conflict_cnt, 64'd14);
      if (i == 10) check("sat_cnt_15", bus.conflict_cnt, 64'd15);
    end
    check("sat_cnt_hold", bus.conflict_cnt, 64'd15);
    idle();
    tick();

    // Mid-cycle reset while a write is in flight.
    drive(1'b1, 5, 32'h55, 1'b0, 0, 32'h0);
    tick();
    idle();
    check("mid_wr_en_before", bus.wr_en, 1'b1);
    #1 clr = 1'b1;
    #1;
    check("mid_wr_en", bus.wr_en, 1'b0);
    check("mid_wr_onehot", bus.wr_onehot, 64'h0);
    check("mid_wr_addr", bus.wr_addr, 64'd0);
    check("mid_conflict_cnt", bus.conflict_cnt, 64'd0);
    clr = 1'b0;
    drive(1'b1, 1, 32'h11, 1'b1, 2, 32'h22);
    #1;
    check("mid_ready0", bus.req0_ready, 1'b1);
    check("mid_ready1", bus.req1_ready, 1'b0);
    idle();
    tick();
    tick();

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
